// File: rtl/speck_key_expander_cache_pkg.sv
// Shared constants, FSM encodings, stream beat type and rotate helpers
// for the SPECK128/128 key expander cache.
package speck_key_expander_cache_pkg;

    localparam int NR_ROUNDS = 32;
    localparam int WORD_W    = 64;
    localparam int ALPHA     = 8;
    localparam int BETA      = 3;
    localparam int IDX_W     = $clog2(NR_ROUNDS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // One beat of the round-key stream.
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] data;
        logic              last;
    } rk_beat_t;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

endpackage

// File: rtl/speck_key_expander_cache_if.sv
// Handshake/bus bundle for speck_key_expander_cache.
//   master: key requester / stream consumer / random reader
//   slave : the expander cache itself
// Signals: start/start_ready/decrypt/key (expansion request),
//   busy, rk_valid/rk_ready/rk_data/rk_idx/rk_last (key stream),
//   cache_valid, rd_en/rd_addr/rd_data (random read port).
interface speck_key_expander_cache_if;
    import speck_key_expander_cache_pkg::*;

    logic                start;
    logic                start_ready;
    logic                decrypt;
    logic [2*WORD_W-1:0] key;
    logic                busy;
    logic                rk_valid;
    logic                rk_ready;
    logic [WORD_W-1:0]   rk_data;
    logic [IDX_W-1:0]    rk_idx;
    logic                rk_last;
    logic                cache_valid;
    logic                rd_en;
    logic [IDX_W-1:0]    rd_addr;
    logic [WORD_W-1:0]   rd_data;

    modport master (
        output start, decrypt, key, rk_ready, rd_en, rd_addr,
        input  start_ready, busy, rk_valid, rk_data, rk_idx, rk_last, cache_valid, rd_data
    );

    modport slave (
        input  start, decrypt, key, rk_ready, rd_en, rd_addr,
        output start_ready, busy, rk_valid, rk_data, rk_idx, rk_last, cache_valid, rd_data
    );
endinterface

// File: rtl/speck_key_expander_cache_step.sv
// One SPECK key-schedule round, purely combinational.
//   k, l, ctr   : current key words and round counter (zero-extended)
//   k_next,l_next: next key words; k is the round key of the current round
module speck_key_step
    import speck_key_expander_cache_pkg::*;
(
    input  logic [WORD_W-1:0] k,
    input  logic [WORD_W-1:0] l,
    input  logic [WORD_W-1:0] ctr,
    output logic [WORD_W-1:0] k_next,
    output logic [WORD_W-1:0] l_next
);
    assign l_next = (k + ror(l, ALPHA)) ^ ctr;
    assign k_next = rol(k, BETA) ^ l_next;
endmodule

// File: rtl/speck_key_expander_cache.sv
// SPECK128/128 key expander with round-key cache.
// Expands a master key one round key per cycle into a register file, then
// streams the set forward (encrypt) or reversed (decrypt); a registered
// random-read port serves the cached set once streaming has finished.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : speck_key_expander_cache_if.slave (request, stream, read)
module speck_key_expander_cache
    import speck_key_expander_cache_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    speck_key_expander_cache_if.slave    bus
);
    logic [1:0]                        state;
    logic [WORD_W-1:0]                 k_q, l_q, k_next, l_next;
    logic [IDX_W-1:0]                  ctr;
    logic                              dec_q;
    logic                              cache_valid;
    logic                              rk_valid;
    rk_beat_t                          beat;
    logic [WORD_W-1:0]                 rd_data;
    logic [NR_ROUNDS-1:0][WORD_W-1:0]  rf;
    logic [IDX_W-1:0]                  first_idx, last_idx, next_idx;
    logic                              idle_or_hold;
    logic                              rd_ok;

    speck_key_step u_step (
        .k      (k_q),
        .l      (l_q),
        .ctr    ({{(WORD_W-IDX_W){1'b0}}, ctr}),
        .k_next (k_next),
        .l_next (l_next)
    );

    always_comb begin
        first_idx = dec_q ? IDX_W'(NR_ROUNDS - 1) : '0;
        last_idx  = dec_q ? '0 : IDX_W'(NR_ROUNDS - 1);
        next_idx  = dec_q ? beat.idx - 1'b1 : beat.idx + 1'b1;
    end

    assign idle_or_hold = (state == ST_IDLE) || (state == ST_HOLD);

    // Register file carries no reset: contents are only trusted once
    // cache_valid is set, which reset clears.
    always_ff @(posedge clk) begin
        if (state == ST_EXPAND)
            rf[ctr] <= k_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            k_q         <= '0;
            l_q         <= '0;
            ctr         <= '0;
            dec_q       <= 1'b0;
            cache_valid <= 1'b0;
            rk_valid    <= 1'b0;
            beat        <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (bus.start) begin
                        state       <= ST_EXPAND;
                        k_q         <= bus.key[WORD_W-1:0];
                        l_q         <= bus.key[2*WORD_W-1:WORD_W];
                        dec_q       <= bus.decrypt;
                        ctr         <= '0;
                        cache_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    k_q <= k_next;
                    l_q <= l_next;
                    ctr <= ctr + 1'b1;
                    if (ctr == IDX_W'(NR_ROUNDS - 1)) begin
                        state       <= ST_STREAM;
                        cache_valid <= 1'b1;
                        beat.idx    <= first_idx;
                    end
                end
                ST_STREAM: begin
                    // First STREAM cycle loads the output register from the
                    // file; afterwards each accepted beat loads the next one
                    // so the stream runs without bubbles.
                    if (!rk_valid) begin
                        rk_valid  <= 1'b1;
                        beat.data <= rf[beat.idx];
                        beat.last <= (beat.idx == last_idx);
                    end else if (bus.rk_ready) begin
                        if (beat.last) begin
                            rk_valid <= 1'b0;
                            state    <= ST_HOLD;
                        end else begin
                            beat.idx  <= next_idx;
                            beat.data <= rf[next_idx];
                            beat.last <= (next_idx == last_idx);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // cache_valid rises on entry to STREAM, but random reads are only served
    // from HOLD so a fresh key set is never exposed mid-stream.
    assign rd_ok = cache_valid && (state == ST_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (bus.rd_en)
            rd_data <= (rd_ok && (int'(bus.rd_addr) < NR_ROUNDS)) ? rf[bus.rd_addr] : '0;
    end

    assign bus.start_ready = idle_or_hold;
    assign bus.busy        = !idle_or_hold;
    assign bus.rk_valid    = rk_valid;
    assign bus.rk_data     = beat.data;
    assign bus.rk_idx      = beat.idx;
    assign bus.rk_last     = beat.last;
    assign bus.cache_valid = cache_valid;
    assign bus.rd_data     = rd_data;
endmodule

// File: tb/tb_speck_key_expander_cache.sv
// Self-checking bench for speck_key_expander_cache: a golden key-schedule
// model fills a scoreboard at start time; stream beats are popped and compared.
module tb_speck_key_expander_cache;
    import speck_key_expander_cache_pkg::*;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [63:0]      data;
        logic             last;
    } exp_t;

    localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a0908_0706050403020100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    exp_t        sb[$];
    logic [63:0] model_rk [NR_ROUNDS];
    logic [63:0] got      [NR_ROUNDS];
    logic [63:0] got_seq[$];

    speck_key_expander_cache_if bus();

    speck_key_expander_cache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] m_rol(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    task automatic gen_model(input logic [127:0] key);
        logic [63:0] k, l;
        k = key[63:0];
        l = key[127:64];
        for (int i = 0; i < NR_ROUNDS; i++) begin
            model_rk[i] = k;
            l = (k + m_ror(l, 8)) ^ 64'(i);
            k = m_rol(k, 3) ^ l;
        end
    endtask

    task automatic push_expected(input bit dec);
        exp_t e;
        sb.delete();
        for (int i = 0; i < NR_ROUNDS; i++) begin
            int j;
            j = dec ? NR_ROUNDS - 1 - i : i;
            e.idx  = IDX_W'(j);
            e.data = model_rk[j];
            e.last = (i == NR_ROUNDS - 1);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge with start_ready high; returns at the negedge
    // after the acceptance edge.
    task automatic issue_start(input logic [127:0] key, input bit dec);
        bus.start   = 1'b1;
        bus.key     = key;
        bus.decrypt = dec;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Drives rk_ready, pops the scoreboard on each transfer and checks stall
    // stability until the DUT returns to HOLD. Cycle counts are relative to
    // the start acceptance edge.
    task automatic drain(input int ready_pct, input bit poke, output int n_xfer,
                         output int t_valid, output int t_hold);
        int          cyc;
        bit          stall;
        logic [63:0] pdata;
        logic [IDX_W-1:0] pidx;
        exp_t        e;
        cyc = 0; stall = 0; pdata = '0; pidx = '0;
        n_xfer = 0; t_valid = -1; t_hold = -1;
        got_seq.delete();
        while (t_hold < 0 && cyc < 600) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.rk_valid && t_valid < 0) t_valid = cyc;
            if (bus.start_ready) begin
                t_hold = cyc;
            end else begin
                if (stall) begin
                    n_checks++;
                    if (bus.rk_data !== pdata || bus.rk_idx !== pidx)
                        $display("FAIL stall_stable: got idx %0d data %h, want idx %0d data %h",
                                 bus.rk_idx, bus.rk_data, pidx, pdata);
                    else n_pass++;
                end
                if (poke && (cyc == 5 || cyc == 40)) begin
                    n_checks++;
                    if (bus.busy !== 1'b1)
                        $display("FAIL poke_busy cyc %0d: got %b want 1", cyc, bus.busy);
                    else n_pass++;
                    bus.start   = 1'b1;
                    bus.key     = {$urandom(), $urandom(), $urandom(), $urandom()};
                    bus.decrypt = ~bus.decrypt;
                end
                bus.rk_ready = ($urandom_range(99) < ready_pct);
                if (bus.rk_valid && bus.rk_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL sb_underflow: got extra beat idx %0d, want none", bus.rk_idx);
                    end else begin
                        e = sb.pop_front();
                        if (bus.rk_data !== e.data || bus.rk_idx !== e.idx || bus.rk_last !== e.last)
                            $display("FAIL xfer: got idx %0d data %h last %b, want idx %0d data %h last %b",
                                     bus.rk_idx, bus.rk_data, bus.rk_last, e.idx, e.data, e.last);
                        else n_pass++;
                    end
                    got[bus.rk_idx] = bus.rk_data;
                    got_seq.push_back(bus.rk_data);
                    n_xfer++;
                end
                stall = bus.rk_valid && !bus.rk_ready;
                pdata = bus.rk_data;
                pidx  = bus.rk_idx;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (t_hold < 0) $display("FAIL drain_timeout: got no HOLD in %0d cycles, want HOLD", cyc);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d beats pending, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.start_ready !== 1'b1) $display("FAIL rst_start_ready: got %b want 1", bus.start_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.rk_valid !== 1'b0) $display("FAIL rst_rk_valid: got %b want 0", bus.rk_valid); else n_pass++;
        n_checks++; if (bus.rk_last !== 1'b0) $display("FAIL rst_rk_last: got %b want 0", bus.rk_last); else n_pass++;
        n_checks++; if (bus.rk_data !== 64'h0) $display("FAIL rst_rk_data: got %h want 0", bus.rk_data); else n_pass++;
        n_checks++; if (bus.rk_idx !== '0) $display("FAIL rst_rk_idx: got %0d want 0", bus.rk_idx); else n_pass++;
        n_checks++; if (bus.cache_valid !== 1'b0) $display("FAIL rst_cache_valid: got %b want 0", bus.cache_valid); else n_pass++;
        n_checks++; if (bus.rd_data !== 64'h0) $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_forward();
        int nx, tv, th;
        gen_model(K1);
        push_expected(1'b0);
        issue_start(K1, 1'b0);
        drain(100, 1'b0, nx, tv, th);
        n_checks++; if (nx != NR_ROUNDS) $display("FAIL fwd_count: got %0d want %0d", nx, NR_ROUNDS); else n_pass++;
        n_checks++; if (tv != NR_ROUNDS + 1) $display("FAIL fwd_first_valid: got %0d want %0d", tv, NR_ROUNDS + 1); else n_pass++;
        n_checks++; if (th != 2 * NR_ROUNDS + 1) $display("FAIL fwd_hold_time: got %0d want %0d", th, 2 * NR_ROUNDS + 1); else n_pass++;
        n_checks++; if (got[0] !== 64'h0706050403020100) $display("FAIL fwd_rk0: got %h want 0706050403020100", got[0]); else n_pass++;
        n_checks++; if (got[1] !== 64'h37253b31171d0309) $display("FAIL fwd_rk1: got %h want 37253b31171d0309", got[1]); else n_pass++;
        n_checks++; if (bus.cache_valid !== 1'b1) $display("FAIL fwd_cache_valid: got %b want 1", bus.cache_valid); else n_pass++;
    endtask

    task automatic test_reverse();
        int nx, tv, th;
        logic [63:0] x, y;
        gen_model(K1);
        push_expected(1'b1);
        issue_start(K1, 1'b1);
        drain(100, 1'b0, nx, tv, th);
        n_checks++; if (nx != NR_ROUNDS) $display("FAIL rev_count: got %0d want %0d", nx, NR_ROUNDS); else n_pass++;
        n_checks++; if (tv != NR_ROUNDS + 1) $display("FAIL rev_first_valid: got %0d want %0d", tv, NR_ROUNDS + 1); else n_pass++;
        // Run the streamed keys through SPECK decryption rounds.
        x = 64'ha65d985179783265;
        y = 64'h7860fedf5c570d18;
        for (int i = 0; i < got_seq.size(); i++) begin
            y = m_ror(x ^ y, 3);
            x = m_rol((x ^ got_seq[i]) - y, 8);
        end
        n_checks++;
        if ({x, y} !== 128'h6c61766975716520_7469206564616d20)
            $display("FAIL rev_decrypt: got %h want 6c617669757165207469206564616d20", {x, y});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int nx, tv, th;
        logic [127:0] k;
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        gen_model(k);
        push_expected(1'b0);
        issue_start(k, 1'b0);
        drain(50, 1'b0, nx, tv, th);
        n_checks++; if (nx != NR_ROUNDS) $display("FAIL bp_count: got %0d want %0d", nx, NR_ROUNDS); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int nx, tv, th;
        gen_model(K1);
        push_expected(1'b0);
        issue_start(K1, 1'b0);
        drain(100, 1'b1, nx, tv, th);
        n_checks++; if (nx != NR_ROUNDS) $display("FAIL ign_count: got %0d want %0d", nx, NR_ROUNDS); else n_pass++;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 5'd1;
        @(posedge clk);
        @(negedge clk);
        bus.rd_en   = 1'b0;
        bus.rd_addr = 5'd7;
        n_checks++; if (bus.rd_data !== 64'h37253b31171d0309) $display("FAIL hold_read1: got %h want 37253b31171d0309", bus.rd_data); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.rd_data !== 64'h37253b31171d0309) $display("FAIL hold_read_keep: got %h want 37253b31171d0309", bus.rd_data); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int nx, tv, th;
        logic [127:0] k2, k3;
        k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        k3 = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.rk_ready = 1'b0;
        issue_start(k2, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1) $display("FAIL abort_exp_state: got busy %b ready %b want 0 1", bus.busy, bus.start_ready); else n_pass++;
        n_checks++; if (bus.cache_valid !== 1'b0) $display("FAIL abort_exp_cache: got %b want 0", bus.cache_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_start(k2, 1'b0);
        for (int i = 0; i < 60 && !bus.rk_valid; i++) @(negedge clk);
        n_checks++; if (bus.rk_valid !== 1'b1) $display("FAIL abort_stream_wait: got rk_valid %b want 1", bus.rk_valid); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.rk_valid !== 1'b0) $display("FAIL abort_rk_valid: got %b want 0", bus.rk_valid); else n_pass++;
        n_checks++; if (bus.rk_data !== 64'h0 || bus.rk_idx !== '0) $display("FAIL abort_rk_out: got %h idx %0d want 0 idx 0", bus.rk_data, bus.rk_idx); else n_pass++;
        n_checks++; if (bus.cache_valid !== 1'b0) $display("FAIL abort_stream_cache: got %b want 0", bus.cache_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        gen_model(k3);
        push_expected(1'b0);
        issue_start(k3, 1'b0);
        drain(100, 1'b0, nx, tv, th);
        n_checks++; if (nx != NR_ROUNDS) $display("FAIL abort_fresh_count: got %0d want %0d", nx, NR_ROUNDS); else n_pass++;
    endtask

    task automatic test_hold_restart();
        int nx, tv, th;
        logic [63:0]  old0;
        logic [127:0] k4;
        old0 = model_rk[0];
        k4 = {$urandom(), $urandom(), $urandom(), ~$urandom()};
        gen_model(k4);
        push_expected(1'b0);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 5'd0;
        issue_start(k4, 1'b0);
        n_checks++; if (bus.rd_data !== old0) $display("FAIL restart_old_rk0: got %h want %h", bus.rd_data, old0); else n_pass++;
        n_checks++; if (bus.cache_valid !== 1'b0) $display("FAIL restart_cache: got %b want 0", bus.cache_valid); else n_pass++;
        bus.rd_addr = 5'd1;
        @(posedge clk);
        @(negedge clk);
        bus.rd_en = 1'b0;
        n_checks++; if (bus.rd_data !== 64'h0) $display("FAIL expand_read: got %h want 0", bus.rd_data); else n_pass++;
        drain(100, 1'b0, nx, tv, th);
        n_checks++; if (nx != NR_ROUNDS) $display("FAIL restart_count: got %0d want %0d", nx, NR_ROUNDS); else n_pass++;
        bus.rd_en   = 1'b1;
        bus.rd_addr = 5'd0;
        @(posedge clk);
        @(negedge clk);
        bus.rd_en = 1'b0;
        n_checks++; if (bus.rd_data !== model_rk[0]) $display("FAIL restart_new_rk0: got %h want %h", bus.rd_data, model_rk[0]); else n_pass++;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.decrypt  = 1'b0;
        bus.key      = '0;
        bus.rk_ready = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_reverse();
        test_backpressure();
        test_ignored_start();
        test_reset_abort();
        test_hold_restart();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
